sun_pll_lock_mon: RTL and testbench

//   Digital controller and lock monitor for the SUN_PLL macro. Drives PWRUP_1V8 to power the PLL,

---
 rtl/sun_pll_lock_mon_if.sv | 39 +++
 rtl/sun_pll_lock_mon.sv | 231 +++++++++++++++++++++++
 tb/tb_sun_pll_lock_mon.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sun_pll_lock_mon_if.sv
// -----------------------------------------------------------------------------
// sun_pll_lock_mon_if
//   Signal bundle between the SUN_PLL macro/system side and the lock monitor.
//   master : drives the enable request and the two PLL clocks, observes status
//   slave  : the lock monitor itself
//   Signals:
//     en         request PLL on (level)
//     ck_ref     reference clock, asynchronous to the monitor clock
//     ck_fb      PLL divided feedback clock, asynchronous to the monitor clock
//     pwrup_1v8  PLL power-up enable
//     locked     PLL frequency-locked
//     lol        one-cycle loss-of-lock pulse
//     fail       sticky acquire failure / missing reference
//     fb_count   feedback edge count of the last completed window (CW bits)
//     state      FSM state: OFF=0 SETTLE=1 MEASURE=2 LOCK=3 FAIL=4
// -----------------------------------------------------------------------------
interface sun_pll_lock_mon_if #(
  parameter int CW = 8
);
  logic          en;
  logic          ck_ref;
  logic          ck_fb;
  logic          pwrup_1v8;
  logic          locked;
  logic          lol;
  logic          fail;
  logic [CW-1:0] fb_count;
  logic [2:0]    state;

  modport master (
    output en, ck_ref, ck_fb,
    input  pwrup_1v8, locked, lol, fail, fb_count, state
  );

  modport slave (
    input  en, ck_ref, ck_fb,
    output pwrup_1v8, locked, lol, fail, fb_count, state
  );
endinterface

// File: rtl/sun_pll_lock_mon.sv
// -----------------------------------------------------------------------------
// sun_pll_lock_mon
//   Controller and frequency-lock monitor for the SUN_PLL macro. Powers the
//   PLL, waits a fixed settle time, then counts feedback edges over windows of
//   WIN reference edges. Declares lock after LOCK_WINDOWS consecutive good
//   windows, pulses lol on loss of lock and raises a sticky fail when lock is
//   not acquired within MAX_WINDOWS windows or the reference disappears.
//   Ports:
//     ck_i   free-running monitor clock (>= 4x ck_ref and ck_fb)
//     rst_i  synchronous active-high reset
//     bus    sun_pll_lock_mon_if.slave (en, ck_ref, ck_fb in; status out)
// -----------------------------------------------------------------------------
module sun_pll_lock_mon #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int WIN           = 16,
  parameter int TOL           = 1,
  parameter int LOCK_WINDOWS  = 4,
  parameter int MAX_WINDOWS   = 64,
  parameter int REF_TIMEOUT   = 4096,
  parameter int CW            = 8
) (
  input  logic              ck_i,
  input  logic              rst_i,
  sun_pll_lock_mon_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCK    = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(WIN + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int NW = $clog2(MAX_WINDOWS + 1);
  localparam int TW = $clog2(REF_TIMEOUT + 1);

  localparam logic [CW-1:0] FB_MAX = '1;
  // Tolerance check runs one bit wider so WIN may exceed the counter range.
  localparam logic [CW:0]   WIN_W  = (CW+1)'(WIN);
  localparam logic [CW:0]   TOL_W  = (CW+1)'(TOL);

  state_e        state_q, state_d;
  logic [1:0]    ref_sync_q, fb_sync_q;
  logic          ref_hist_q, fb_hist_q;
  logic          ref_pulse, fb_pulse;
  logic [SW-1:0] settle_q, settle_d;
  logic          win_open_q, win_open_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [CW-1:0] fb_cnt_q, fb_cnt_d;
  logic [CW-1:0] fb_count_q, fb_count_d;
  logic [GW-1:0] good_run_q, good_run_d;
  logic [NW-1:0] win_num_q, win_num_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          pwrup_q, locked_q, lol_q, fail_q, lol_d;
  logic          measuring, win_close, timeout, win_good;
  logic [CW-1:0] count_final;
  logic [CW:0]   count_w, diff_w;

  // Rising-edge pulses from the synchronized clocks (history flop holds the
  // previous synchronized level).
  assign ref_pulse = ref_sync_q[1] & ~ref_hist_q;
  assign fb_pulse  = fb_sync_q[1]  & ~fb_hist_q;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    win_open_d  = win_open_q;
    ref_cnt_d   = ref_cnt_q;
    fb_cnt_d    = fb_cnt_q;
    good_run_d  = good_run_q;
    win_num_d   = win_num_q;
    wdog_d      = wdog_q;
    lol_d       = 1'b0;
    win_close   = 1'b0;
    count_final = fb_cnt_q;

    measuring = (state_q == ST_MEASURE) || (state_q == ST_LOCK);

    // Window tracking: back-to-back windows of WIN reference periods.
    if (measuring) begin
      if (!win_open_q) begin
        if (ref_pulse) begin
          win_open_d = 1'b1;
          ref_cnt_d  = '0;
          fb_cnt_d   = fb_pulse ? CW'(1) : '0;
        end
      end else begin
        if (fb_pulse && (fb_cnt_q != FB_MAX)) fb_cnt_d = fb_cnt_q + 1'b1;
        if (ref_pulse) begin
          if (ref_cnt_q == RW'(WIN - 1)) begin
            // A coincident feedback edge already landed in fb_cnt_d and
            // belongs to the closing window; the next window starts at zero.
            win_close   = 1'b1;
            count_final = fb_cnt_d;
            ref_cnt_d   = '0;
            fb_cnt_d    = '0;
          end else begin
            ref_cnt_d = ref_cnt_q + 1'b1;
          end
        end
      end
      wdog_d = ref_pulse ? '0 : wdog_q + 1'b1;
    end

    timeout = measuring && !ref_pulse && (wdog_q == TW'(REF_TIMEOUT - 1));

    count_w  = {1'b0, count_final};
    diff_w   = (count_w >= WIN_W) ? (count_w - WIN_W) : (WIN_W - count_w);
    win_good = (diff_w <= TOL_W);

    case (state_q)
      ST_OFF: begin
        if (bus.en) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (timeout) begin
          state_d = ST_FAIL;
        end else if (win_close) begin
          win_num_d = win_num_q + 1'b1;
          if (win_good) begin
            good_run_d = good_run_q + 1'b1;
            if (good_run_q == GW'(LOCK_WINDOWS - 1)) state_d = ST_LOCK;
          end else begin
            good_run_d = '0;
          end
          if ((state_d != ST_LOCK) && (win_num_q == NW'(MAX_WINDOWS - 1)))
            state_d = ST_FAIL;
        end
      end
      ST_LOCK: begin
        if (timeout) begin
          state_d = ST_FAIL;
          lol_d   = 1'b1;
        end else if (win_close && !win_good) begin
          state_d    = ST_MEASURE;
          lol_d      = 1'b1;
          good_run_d = '0;
          win_num_d  = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // A commanded power-down overrides everything and is silent.
    if (!bus.en) begin
      state_d = ST_OFF;
      lol_d   = 1'b0;
    end

    if (state_d != ST_SETTLE) settle_d = '0;

    // Leaving the measuring states discards the partial window and history.
    if ((state_d != ST_MEASURE) && (state_d != ST_LOCK)) begin
      win_open_d = 1'b0;
      ref_cnt_d  = '0;
      fb_cnt_d   = '0;
      good_run_d = '0;
      win_num_d  = '0;
      wdog_d     = '0;
    end

    fb_count_d = (win_close && bus.en) ? count_final : fb_count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q    <= ST_OFF;
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      ref_hist_q <= 1'b0;
      fb_hist_q  <= 1'b0;
      settle_q   <= '0;
      win_open_q <= 1'b0;
      ref_cnt_q  <= '0;
      fb_cnt_q   <= '0;
      fb_count_q <= '0;
      good_run_q <= '0;
      win_num_q  <= '0;
      wdog_q     <= '0;
      pwrup_q    <= 1'b0;
      locked_q   <= 1'b0;
      lol_q      <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_sync_q <= {ref_sync_q[0], bus.ck_ref};
      fb_sync_q  <= {fb_sync_q[0], bus.ck_fb};
      ref_hist_q <= ref_sync_q[1];
      fb_hist_q  <= fb_sync_q[1];
      settle_q   <= settle_d;
      win_open_q <= win_open_d;
      ref_cnt_q  <= ref_cnt_d;
      fb_cnt_q   <= fb_cnt_d;
      fb_count_q <= fb_count_d;
      good_run_q <= good_run_d;
      win_num_q  <= win_num_d;
      wdog_q     <= wdog_d;
      // Status flops are decoded from the next state so they change in the
      // same cycle as the state register.
      pwrup_q    <= state_d inside {ST_SETTLE, ST_MEASURE, ST_LOCK};
      locked_q   <= (state_d == ST_LOCK);
      fail_q     <= (state_d == ST_FAIL);
      lol_q      <= lol_d;
    end
  end

  assign bus.pwrup_1v8 = pwrup_q;
  assign bus.locked    = locked_q;
  assign bus.lol       = lol_q;
  assign bus.fail      = fail_q;
  assign bus.fb_count  = fb_count_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_sun_pll_lock_mon.sv
// -----------------------------------------------------------------------------
// tb_sun_pll_lock_mon
//   Bench for sun_pll_lock_mon. CK_REF runs at CK/40; CK_FB comes from a
//   phase accumulator that yields exactly fb_step rising edges per 640 CK
//   cycles (one 16-reference window). A second instance with CW=4 covers
//   counter saturation. Expected window counts go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_sun_pll_lock_mon;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  sun_pll_lock_mon_if #(.CW(8)) m_if ();
  sun_pll_lock_mon_if #(.CW(4)) s_if ();

  sun_pll_lock_mon dut (
    .ck_i  (ck),
    .rst_i (rst),
    .bus   (m_if)
  );

  sun_pll_lock_mon #(.SETTLE_CYCLES(16), .CW(4)) dut_sat (
    .ck_i  (ck),
    .rst_i (rst),
    .bus   (s_if)
  );

  always #5 ck = ~ck;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected window counts.
  int    sb_q[$];
  string sb_name_q[$];

  // Clock generators, updated away from the sampling edge.
  int ref_ph    = 0;
  int acc       = 0;
  int fb_step   = 16;
  bit ref_run   = 1'b1;
  bit phase_rst = 1'b0;

  always @(negedge ck) begin
    if (phase_rst) begin
      ref_ph = 0;
      acc    = 320;
    end else begin
      ref_ph = (ref_ph == 39) ? 0 : ref_ph + 1;
      acc    = (acc + fb_step) % 640;
    end
    m_if.ck_ref = ref_run && (ref_ph < 20);
    m_if.ck_fb  = (acc >= 320);
    s_if.ck_ref = m_if.ck_ref;
    s_if.ck_fb  = m_if.ck_fb;
  end

  // Event monitors for the main instance.
  int lol_cnt    = 0;
  int locked_cnt = 0;
  always @(negedge ck) begin
    if (m_if.lol === 1'b1)    lol_cnt++;
    if (m_if.locked === 1'b1) locked_cnt++;
  end

  task automatic sb_push(input string name, input int val);
    sb_name_q.push_back(name);
    sb_q.push_back(val);
  endtask

  // Waits on a main-instance condition; n == budget means it never happened.
  // what: 0 state MEASURE, 1 locked, 2 fail, 3 lol, 4 state OFF
  task automatic wait_main(input int what, input int budget, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge ck); #1;
      n++;
      case (what)
        0:       hit = (m_if.state === 3'd2);
        1:       hit = (m_if.locked === 1'b1);
        2:       hit = (m_if.fail === 1'b1);
        3:       hit = (m_if.lol === 1'b1);
        default: hit = (m_if.state === 3'd0);
      endcase
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    m_if.en = 1'b0;
    s_if.en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    obs = {m_if.state, m_if.pwrup_1v8, m_if.locked, m_if.lol, m_if.fail, m_if.fb_count, 1'b0};
    total++;
    if (obs !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0000", obs);
    end
    @(negedge ck) m_if.en = 1'b1;
    @(posedge ck); #1;
    obs = {m_if.state, m_if.pwrup_1v8, m_if.locked, m_if.lol, m_if.fail, m_if.fb_count, 1'b0};
    total++;
    if (obs !== 16'h0) begin
      bad++;
      $display("FAIL reset_with_en got=%h want=0000", obs);
    end
    @(negedge ck);
    m_if.en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_settle();
    int n;
    @(negedge ck) m_if.en = 1'b1;
    @(posedge ck); #1;
    total++;
    if ({m_if.pwrup_1v8, m_if.state} !== 4'b1_001) begin
      bad++;
      $display("FAIL settle_entry got pwrup=%b state=%0d want pwrup=1 state=1",
               m_if.pwrup_1v8, m_if.state);
    end
    wait_main(0, 2000, n);
    total++;
    if (n != 1024) begin
      bad++;
      $display("FAIL settle_length got=%0d want=1024", n);
    end
  endtask

  task automatic test_lock();
    int n, exp, lol0;
    logic [31:0] obs;
    lol0 = lol_cnt;
    sb_push("lock_fb_count", 16);
    wait_main(1, 4000, n);
    total++;
    if (n < 2561 || n > 2602) begin
      bad++;
      $display("FAIL lock_time got=%0d want=2561..2602", n);
    end
    total++;
    if (m_if.state !== 3'd3) begin
      bad++;
      $display("FAIL lock_state got=%0d want=3", m_if.state);
    end
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    total++;
    if (lol_cnt != lol0) begin
      bad++;
      $display("FAIL lock_no_lol got=%0d want=0", lol_cnt - lol0);
    end
  endtask

  task automatic test_bad_freq();
    int n, exp, lk0;
    logic [31:0] obs;
    @(negedge ck) m_if.en = 1'b0;
    repeat (2) @(negedge ck);
    fb_step = 20;
    m_if.en = 1'b1;
    wait_main(0, 1100, n);
    lk0 = locked_cnt;
    sb_push("bad_fb_count", 20);
    wait_main(2, 45000, n);
    total++;
    if (n < 40961 || n > 41002) begin
      bad++;
      $display("FAIL fail_time got=%0d want=40961..41002", n);
    end
    total++;
    if ({m_if.fail, m_if.pwrup_1v8, m_if.locked, m_if.state} !== 6'b1_0_0_100) begin
      bad++;
      $display("FAIL fail_outputs got fail=%b pwrup=%b locked=%b state=%0d want 1 0 0 4",
               m_if.fail, m_if.pwrup_1v8, m_if.locked, m_if.state);
    end
    total++;
    if (locked_cnt != lk0) begin
      bad++;
      $display("FAIL bad_never_locked got=%0d want=0", locked_cnt - lk0);
    end
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    @(negedge ck) m_if.en = 1'b0;
    @(posedge ck); #1;
    total++;
    if ({m_if.state, m_if.fail} !== 4'b000_0) begin
      bad++;
      $display("FAIL fail_exit got state=%0d fail=%b want state=0 fail=0",
               m_if.state, m_if.fail);
    end
  endtask

  task automatic test_lol();
    int n, exp, lol0;
    logic [31:0] obs;
    @(negedge ck);
    fb_step = 16;
    m_if.en = 1'b1;
    wait_main(0, 1100, n);
    wait_main(1, 4000, n);
    total++;
    if (n >= 4000) begin
      bad++;
      $display("FAIL lol_prelock got=timeout want=locked");
    end
    lol0 = lol_cnt;
    @(negedge ck) fb_step = 18;
    sb_push("lol_fb_count", 18);
    wait_main(3, 3000, n);
    total++;
    if ({m_if.lol, m_if.state, m_if.locked} !== 5'b1_010_0) begin
      bad++;
      $display("FAIL lol_event got lol=%b state=%0d locked=%b want 1 2 0",
               m_if.lol, m_if.state, m_if.locked);
    end
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    fb_step = 16;
    @(posedge ck); #1;
    total++;
    if (m_if.lol !== 1'b0) begin
      bad++;
      $display("FAIL lol_width got=%b want=0", m_if.lol);
    end
    wait_main(1, 4000, n);
    total++;
    if (n < 2500 || n > 3250) begin
      bad++;
      $display("FAIL relock_time got=%0d want=2500..3250", n);
    end
    total++;
    if (lol_cnt != lol0 + 1) begin
      bad++;
      $display("FAIL lol_count got=%0d want=1", lol_cnt - lol0);
    end
    @(negedge ck) fb_step = 17;
    sb_push("tol_fb_count", 17);
    repeat (6 * 640) @(posedge ck);
    #1;
    total++;
    if (m_if.locked !== 1'b1 || lol_cnt != lol0 + 1) begin
      bad++;
      $display("FAIL tol_stays_locked got locked=%b lol_pulses=%0d want 1 1",
               m_if.locked, lol_cnt - lol0);
    end
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
  endtask

  task automatic test_ref_loss();
    int n;
    @(negedge ck) ref_run = 1'b0;
    wait_main(2, 5000, n);
    total++;
    if (n < 4040 || n > 4105) begin
      bad++;
      $display("FAIL ref_timeout got=%0d want=4040..4105", n);
    end
    total++;
    if ({m_if.fail, m_if.lol, m_if.locked, m_if.pwrup_1v8} !== 4'b1100) begin
      bad++;
      $display("FAIL ref_loss_outputs got fail=%b lol=%b locked=%b pwrup=%b want 1 1 0 0",
               m_if.fail, m_if.lol, m_if.locked, m_if.pwrup_1v8);
    end
  endtask

  task automatic test_en_drop();
    int n, exp, lol0;
    logic [31:0] obs;
    @(negedge ck);
    m_if.en = 1'b0;
    ref_run = 1'b1;
    fb_step = 16;
    repeat (2) @(negedge ck);
    m_if.en = 1'b1;
    wait_main(0, 1100, n);
    repeat (2240) @(posedge ck);
    #1;
    total++;
    if (m_if.state !== 3'd2) begin
      bad++;
      $display("FAIL en_drop_pre got state=%0d want=2", m_if.state);
    end
    lol0 = lol_cnt;
    sb_push("en_drop_fb_count", 16);
    @(negedge ck) m_if.en = 1'b0;
    @(posedge ck); #1;
    total++;
    if ({m_if.state, m_if.pwrup_1v8, m_if.locked, m_if.fail} !== 6'b000_000) begin
      bad++;
      $display("FAIL en_drop_off got state=%0d pwrup=%b locked=%b fail=%b want 0 0 0 0",
               m_if.state, m_if.pwrup_1v8, m_if.locked, m_if.fail);
    end
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    repeat (4) @(posedge ck);
    #1;
    total++;
    if (lol_cnt != lol0) begin
      bad++;
      $display("FAIL en_drop_no_lol got=%0d want=0", lol_cnt - lol0);
    end
  endtask

  task automatic test_saturate();
    int n, exp;
    logic [31:0] obs;
    @(negedge ck);
    fb_step = 160;
    s_if.en = 1'b1;
    n = 0;
    while (s_if.state !== 3'd2 && n < 100) begin
      @(posedge ck); #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL sat_measure got state=%0d want=2", s_if.state);
    end
    sb_push("sat_fb_count", 15);
    repeat (1400) @(posedge ck);
    #1;
    exp = sb_q.pop_front();
    obs = {28'h0, s_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    @(negedge ck) s_if.en = 1'b0;
  endtask

  task automatic test_align();
    int n, exp;
    logic [31:0] obs;
    @(negedge ck);
    fb_step = 16;
    phase_rst = 1'b1;
    repeat (2) @(negedge ck);
    phase_rst = 1'b0;
    m_if.en = 1'b1;
    wait_main(0, 1100, n);
    // Opening cycle counts 1 and the closing coincident edge counts too.
    sb_push("align_first_window", 17);
    sb_push("align_steady_window", 16);
    repeat (700) @(posedge ck);
    #1;
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    repeat (640) @(posedge ck);
    #1;
    exp = sb_q.pop_front();
    obs = {24'h0, m_if.fb_count};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", sb_name_q.pop_front(), obs, exp);
    end else void'(sb_name_q.pop_front());
    @(negedge ck) m_if.en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_lock();
    test_bad_freq();
    test_lol();
    test_ref_loss();
    test_en_drop();
    test_saturate();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
